systolic_array_pe_mm: RTL and testbench

Multi-mode processing element for the GEMM systolic array, successor to the output-stationary PE. It adds four things: parametrised signedness, a weight-stationary mode alongside output-stationary, a counted drain state machine that forwards upstream results, and a sticky protocol-error flag. One PE instance sits at each grid point. Operands flow left→right, and operands, partial sums and drained results flow top→down.

---
 rtl/sa_pe_pkg.sv | 28 ++
 rtl/sa_pe_mac.sv | 48 ++++
 rtl/systolic_array_pe_mm.sv | 147 ++++++++++++++
 tb/tb_systolic_array_pe_mm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pe_pkg.sv
// Shared types for the systolic-array PE: top-opcode and FSM-state encodings,
// plus the drain-counter width helper.
package sa_pe_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_OS_MAC = 3'b001,
        OP_CLEAR  = 3'b010,
        OP_DRAIN  = 3'b011,
        OP_LOAD_W = 3'b100,
        OP_WS_MAC = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // clog2(rows), never below 1 so a single-row array still gets a counter bit
    function automatic int cnt_width(input int rows);
        int w;
        w = 1;
        while ((1 << w) < rows) w++;
        return w;
    endfunction

endpackage

// File: rtl/sa_pe_mac.sv
// Combinational multiply-extend-add shared by the OS and WS paths.
// Saturating add when SA_PE_SATURATE_EN is defined, wrap-around otherwise.
module sa_pe_mac #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [OUT_W-1:0] addend,
    output logic [OUT_W-1:0] sum
);

    logic             a_sx;
    logic             b_sx;
    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic [OUT_W-1:0] prod;

    assign a_sx  = (SIGNED != 0) & a[IN_W-1];
    assign b_sx  = (SIGNED != 0) & b[IN_W-1];
    assign a_ext = {{(OUT_W-IN_W){a_sx}}, a};
    assign b_ext = {{(OUT_W-IN_W){b_sx}}, b};
    // Low OUT_W bits of the extended product equal the exact 2*IN_W product, extended.
    assign prod  = a_ext * b_ext;

`ifdef SA_PE_SATURATE_EN
    logic [OUT_W:0] wide;
    logic           ovf;

    always_comb begin
        wide = {1'b0, addend} + {1'b0, prod};
        if (SIGNED != 0) begin
            ovf = (addend[OUT_W-1] == prod[OUT_W-1]) && (wide[OUT_W-1] != addend[OUT_W-1]);
            if (ovf)
                sum = addend[OUT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            else
                sum = wide[OUT_W-1:0];
        end else begin
            ovf = wide[OUT_W];
            sum = ovf ? '1 : wide[OUT_W-1:0];
        end
    end
`else
    assign sum = addend + prod;
`endif

endmodule

// File: rtl/systolic_array_pe_mm.sv
// Multi-mode GEMM PE: output-stationary / weight-stationary MAC, counted drain chain,
// sticky protocol-error flag. Optional clamp arithmetic via SA_PE_SATURATE_EN.
module systolic_array_pe_mm
    import sa_pe_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 32,
    parameter int SIGNED      = 1,
    parameter int ROW_ID      = 0,
    parameter int LAST_ROW_ID = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  i_data_left,
    input  logic             i_valid_left,
    input  logic             i_cmd_left,
    output logic [IN_W-1:0]  o_data_right,
    output logic             o_valid_right,
    output logic             o_cmd_right,
    input  logic [OUT_W-1:0] i_data_top,
    input  logic             i_valid_top,
    input  logic [2:0]       i_cmd_top,
    output logic [OUT_W-1:0] o_data_down,
    output logic             o_valid_down,
    output logic [2:0]       o_cmd_down,
    output logic             o_busy,
    output logic             o_err
);

    localparam int CNT_W = cnt_width(LAST_ROW_ID + 1);

    state_t           state, state_nxt;
    logic [OUT_W-1:0] acc, acc_nxt;
    logic [IN_W-1:0]  weight, weight_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             err_nxt;
    logic [OUT_W-1:0] down_data_nxt;
    logic             down_valid_nxt;
    logic             mac_ok;
    logic             ws_sel;
    logic [IN_W-1:0]  mac_b;
    logic [OUT_W-1:0] mac_addend;
    logic [OUT_W-1:0] mac_sum;

    assign mac_ok     = i_valid_left & i_valid_top & i_cmd_left;
    assign ws_sel     = (i_cmd_top == OP_WS_MAC);
    assign mac_b      = ws_sel ? weight : i_data_top[IN_W-1:0];
    assign mac_addend = ws_sel ? i_data_top : acc;
    assign cnt_inc    = cnt + 1'b1;
    assign o_busy     = (state == ST_DRAIN);

    sa_pe_mac #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .a      (i_data_left),
        .b      (mac_b),
        .addend (mac_addend),
        .sum    (mac_sum)
    );

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        weight_nxt     = weight;
        cnt_nxt        = cnt;
        err_nxt        = o_err;
        down_data_nxt  = i_data_top;
        down_valid_nxt = i_valid_top;

        if (state == ST_DRAIN) begin
            // Upstream words pass straight through; a repeated DRAIN is just forwarding.
            if (i_valid_top) begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == CNT_W'(ROW_ID)) state_nxt = ST_IDLE;
            end
            case (i_cmd_top)
                OP_OS_MAC, OP_CLEAR, OP_LOAD_W, OP_WS_MAC: err_nxt = 1'b1;
                default: ;
            endcase
        end else begin
            case (i_cmd_top)
                OP_OS_MAC: begin
                    if (mac_ok) begin
                        acc_nxt   = mac_sum;
                        state_nxt = ST_ACC;
                    end
                end
                OP_CLEAR: begin
                    acc_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
                OP_DRAIN: begin
                    down_data_nxt  = acc;
                    down_valid_nxt = 1'b1;
                    acc_nxt        = '0;
                    cnt_nxt        = '0;
                    state_nxt      = (ROW_ID == 0) ? ST_IDLE : ST_DRAIN;
                end
                OP_LOAD_W: begin
                    if (i_valid_top) begin
                        weight_nxt     = i_data_top[IN_W-1:0];
                        down_data_nxt  = {{(OUT_W-IN_W){1'b0}}, weight};
                        down_valid_nxt = 1'b1;
                    end
                end
                OP_WS_MAC: begin
                    if (mac_ok) begin
                        down_data_nxt  = mac_sum;
                        down_valid_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            acc           <= '0;
            weight        <= '0;
            cnt           <= '0;
            o_err         <= 1'b0;
            o_data_right  <= '0;
            o_valid_right <= 1'b0;
            o_cmd_right   <= 1'b0;
            o_data_down   <= '0;
            o_valid_down  <= 1'b0;
            o_cmd_down    <= '0;
        end else begin
            state         <= state_nxt;
            acc           <= acc_nxt;
            weight        <= weight_nxt;
            cnt           <= cnt_nxt;
            o_err         <= err_nxt;
            o_data_right  <= i_data_left;
            o_valid_right <= i_valid_left;
            o_cmd_right   <= i_cmd_left;
            o_data_down   <= down_data_nxt;
            o_valid_down  <= down_valid_nxt;
            o_cmd_down    <= i_cmd_top;
        end
    end

endmodule

// File: tb/tb_systolic_array_pe_mm.sv
// Directed self-checking bench for systolic_array_pe_mm; several parameterisations share one stimulus bus.
module tb_systolic_array_pe_mm;

    localparam logic [2:0] NOP = 3'b000, OS = 3'b001, CLR = 3'b010, DRN = 3'b011,
                           LDW = 3'b100, WS = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dl  = '0;
    logic        vl  = 1'b0, cl = 1'b0;
    logic [31:0] dt  = '0;
    logic        vt  = 1'b0;
    logic [2:0]  ct  = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // a: row 0 signed, b: row 2, c: row 3, u: row 0 unsigned, s: row 0 16-bit
    logic [7:0]  a_dr, b_dr, c_dr, u_dr, s_dr;
    logic        a_vr, b_vr, c_vr, u_vr, s_vr;
    logic        a_cr, b_cr, c_cr, u_cr, s_cr;
    logic [31:0] a_dd, b_dd, c_dd, u_dd;
    logic [15:0] s_dd;
    logic        a_vd, b_vd, c_vd, u_vd, s_vd;
    logic [2:0]  a_cd, b_cd, c_cd, u_cd, s_cd;
    logic        a_busy, b_busy, c_busy, u_busy, s_busy;
    logic        a_err, b_err, c_err, u_err, s_err;

    systolic_array_pe_mm #(.IN_W(8), .OUT_W(32), .SIGNED(1), .ROW_ID(0), .LAST_ROW_ID(3)) u_a (
        .clk(clk), .rst(rst), .i_data_left(dl), .i_valid_left(vl), .i_cmd_left(cl),
        .o_data_right(a_dr), .o_valid_right(a_vr), .o_cmd_right(a_cr),
        .i_data_top(dt), .i_valid_top(vt), .i_cmd_top(ct),
        .o_data_down(a_dd), .o_valid_down(a_vd), .o_cmd_down(a_cd), .o_busy(a_busy), .o_err(a_err));

    systolic_array_pe_mm #(.IN_W(8), .OUT_W(32), .SIGNED(1), .ROW_ID(2), .LAST_ROW_ID(3)) u_b (
        .clk(clk), .rst(rst), .i_data_left(dl), .i_valid_left(vl), .i_cmd_left(cl),
        .o_data_right(b_dr), .o_valid_right(b_vr), .o_cmd_right(b_cr),
        .i_data_top(dt), .i_valid_top(vt), .i_cmd_top(ct),
        .o_data_down(b_dd), .o_valid_down(b_vd), .o_cmd_down(b_cd), .o_busy(b_busy), .o_err(b_err));

    systolic_array_pe_mm #(.IN_W(8), .OUT_W(32), .SIGNED(1), .ROW_ID(3), .LAST_ROW_ID(3)) u_c (
        .clk(clk), .rst(rst), .i_data_left(dl), .i_valid_left(vl), .i_cmd_left(cl),
        .o_data_right(c_dr), .o_valid_right(c_vr), .o_cmd_right(c_cr),
        .i_data_top(dt), .i_valid_top(vt), .i_cmd_top(ct),
        .o_data_down(c_dd), .o_valid_down(c_vd), .o_cmd_down(c_cd), .o_busy(c_busy), .o_err(c_err));

    systolic_array_pe_mm #(.IN_W(8), .OUT_W(32), .SIGNED(0), .ROW_ID(0), .LAST_ROW_ID(3)) u_u (
        .clk(clk), .rst(rst), .i_data_left(dl), .i_valid_left(vl), .i_cmd_left(cl),
        .o_data_right(u_dr), .o_valid_right(u_vr), .o_cmd_right(u_cr),
        .i_data_top(dt), .i_valid_top(vt), .i_cmd_top(ct),
        .o_data_down(u_dd), .o_valid_down(u_vd), .o_cmd_down(u_cd), .o_busy(u_busy), .o_err(u_err));

    systolic_array_pe_mm #(.IN_W(8), .OUT_W(16), .SIGNED(1), .ROW_ID(0), .LAST_ROW_ID(3)) u_s (
        .clk(clk), .rst(rst), .i_data_left(dl), .i_valid_left(vl), .i_cmd_left(cl),
        .o_data_right(s_dr), .o_valid_right(s_vr), .o_cmd_right(s_cr),
        .i_data_top(dt[15:0]), .i_valid_top(vt), .i_cmd_top(ct),
        .o_data_down(s_dd), .o_valid_down(s_vd), .o_cmd_down(s_cd), .o_busy(s_busy), .o_err(s_err));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d_l, input logic v_l, input logic c_l,
                         input logic [31:0] d_t, input logic v_t, input logic [2:0] c_t);
        dl = d_l; vl = v_l; cl = c_l; dt = d_t; vt = v_t; ct = c_t;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dl = '0; vl = 1'b0; cl = 1'b0; dt = '0; vt = 1'b0; ct = NOP;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(8'hFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, DRN);
        checks++; if (a_dd !== 32'd0) begin errors++; $display("FAIL reset_data_down: got %0h want 0", a_dd); end
        checks++; if (a_vd !== 1'b0) begin errors++; $display("FAIL reset_valid_down: got %0b want 0", a_vd); end
        checks++; if (a_cd !== 3'd0) begin errors++; $display("FAIL reset_cmd_down: got %0d want 0", a_cd); end
        checks++; if (a_dr !== 8'd0 || a_vr !== 1'b0 || a_cr !== 1'b0) begin errors++; $display("FAIL reset_right: got %0h/%0b/%0b want 0/0/0", a_dr, a_vr, a_cr); end
        checks++; if (c_busy !== 1'b0 || c_err !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got %0b/%0b want 0/0", c_busy, c_err); end
        rst = 1'b0;
    endtask

    task automatic test_forward();
        do_reset();
        drive(8'h5A, 1'b1, 1'b1, 32'h1234_5678, 1'b1, NOP);
        checks++; if (a_dr !== 8'h5A || a_vr !== 1'b1 || a_cr !== 1'b1) begin errors++; $display("FAIL fwd_right: got %0h/%0b/%0b want 5a/1/1", a_dr, a_vr, a_cr); end
        checks++; if (a_dd !== 32'h1234_5678 || a_vd !== 1'b1) begin errors++; $display("FAIL fwd_down: got %0h/%0b want 12345678/1", a_dd, a_vd); end
        drive(8'h00, 1'b0, 1'b0, 32'h0000_DEAD, 1'b0, 3'b110);
        checks++; if (a_cd !== 3'b110 || a_vd !== 1'b0 || a_dd !== 32'h0000_DEAD) begin errors++; $display("FAIL fwd_reserved: got cmd %0d valid %0b data %0h want 6/0/dead", a_cd, a_vd, a_dd); end
    endtask

    task automatic test_os_accumulate();
        do_reset();
        drive(8'd3, 1'b1, 1'b1, 32'd4, 1'b1, OS);
        checks++; if (a_dd !== 32'd4 || a_vd !== 1'b1) begin errors++; $display("FAIL os_top_fwd: got %0d/%0b want 4/1", a_dd, a_vd); end
        drive(8'hFE, 1'b1, 1'b1, 32'd5, 1'b1, OS);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        checks++; if (a_dd !== 32'd2 || a_vd !== 1'b1 || a_cd !== DRN) begin errors++; $display("FAIL os_drain: got %0d/%0b/%0d want 2/1/3", $signed(a_dd), a_vd, a_cd); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL os_row0_idle: got busy %0b want 0", a_busy); end
        checks++; if (u_dd !== 32'd1282) begin errors++; $display("FAIL os_unsigned: got %0d want 1282", u_dd); end
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        checks++; if (a_dd !== 32'd0 || a_vd !== 1'b1) begin errors++; $display("FAIL os_acc_cleared: got %0d/%0b want 0/1", a_dd, a_vd); end
    endtask

    task automatic test_no_mac_and_clear();
        do_reset();
        drive(8'd5, 1'b1, 1'b1, 32'd5, 1'b0, OS);
        checks++; if (a_vd !== 1'b0 || a_dd !== 32'd5) begin errors++; $display("FAIL nomac_fwd: got %0d/%0b want 5/0", a_dd, a_vd); end
        drive(8'd5, 1'b0, 1'b1, 32'd5, 1'b1, OS);
        drive(8'd5, 1'b1, 1'b0, 32'd5, 1'b1, OS);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        checks++; if (a_dd !== 32'd0) begin errors++; $display("FAIL nomac_acc: got %0d want 0", a_dd); end
        drive(8'd7, 1'b1, 1'b1, 32'd7, 1'b1, OS);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, CLR);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        checks++; if (a_dd !== 32'd0 || a_vd !== 1'b1) begin errors++; $display("FAIL clear_acc: got %0d/%0b want 0/1", a_dd, a_vd); end
    endtask

    task automatic test_drain_chain();
        do_reset();
        drive(8'd5, 1'b1, 1'b1, 32'd1, 1'b1, OS);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        checks++; if (b_dd !== 32'd5 || b_vd !== 1'b1 || b_busy !== 1'b1) begin errors++; $display("FAIL chain_own: got %0d/%0b busy %0b want 5/1/1", b_dd, b_vd, b_busy); end
        drive(8'd0, 1'b0, 1'b0, 32'd7, 1'b1, DRN);
        checks++; if (b_dd !== 32'd7 || b_vd !== 1'b1 || b_busy !== 1'b1 || b_err !== 1'b0) begin errors++; $display("FAIL chain_w1: got %0d/%0b busy %0b err %0b want 7/1/1/0", b_dd, b_vd, b_busy, b_err); end
        drive(8'd0, 1'b0, 1'b0, 32'd9, 1'b1, NOP);
        checks++; if (b_dd !== 32'd9 || b_vd !== 1'b1 || b_busy !== 1'b0) begin errors++; $display("FAIL chain_w2: got %0d/%0b busy %0b want 9/1/0", b_dd, b_vd, b_busy); end
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, NOP);
        checks++; if (b_vd !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL chain_done: got valid %0b busy %0b want 0/0", b_vd, b_busy); end
    endtask

    task automatic test_ws();
        do_reset();
        drive(8'd0, 1'b0, 1'b0, 32'd6, 1'b1, LDW);
        checks++; if (a_dd !== 32'd0 || a_vd !== 1'b1) begin errors++; $display("FAIL ws_load1: got %0d/%0b want 0/1", a_dd, a_vd); end
        drive(8'd3, 1'b1, 1'b1, 32'd10, 1'b1, WS);
        checks++; if (a_dd !== 32'd28 || a_vd !== 1'b1) begin errors++; $display("FAIL ws_mac: got %0d/%0b want 28/1", a_dd, a_vd); end
        drive(8'd0, 1'b0, 1'b0, 32'd9, 1'b1, LDW);
        checks++; if (a_dd !== 32'd6 || a_vd !== 1'b1) begin errors++; $display("FAIL ws_shift: got %0d/%0b want 6/1", a_dd, a_vd); end
        drive(8'd3, 1'b1, 1'b0, 32'd10, 1'b1, WS);
        checks++; if (a_dd !== 32'd10 || a_vd !== 1'b1) begin errors++; $display("FAIL ws_passthru: got %0d/%0b want 10/1", a_dd, a_vd); end
        drive(8'd3, 1'b1, 1'b1, 32'd10, 1'b0, WS);
        checks++; if (a_vd !== 1'b0) begin errors++; $display("FAIL ws_novalid: got %0b want 0", a_vd); end
        drive(8'hFF, 1'b1, 1'b1, 32'd4, 1'b1, WS);
        checks++; if (a_dd !== 32'hFFFF_FFFB) begin errors++; $display("FAIL ws_signed: got %0d want -5", $signed(a_dd)); end
        checks++; if (u_dd !== 32'd2299) begin errors++; $display("FAIL ws_unsigned: got %0d want 2299", u_dd); end
    endtask

    task automatic test_saturate();
        logic [15:0] exp16;
`ifdef SA_PE_SATURATE_EN
        exp16 = 16'h7FFF;
`else
        exp16 = 16'h8077;
`endif
        do_reset();
        drive(8'd127, 1'b1, 1'b1, 32'd127, 1'b1, OS);
        drive(8'd127, 1'b1, 1'b1, 32'd127, 1'b1, OS);
        drive(8'd127, 1'b1, 1'b1, 32'd3, 1'b1, OS);
        drive(8'd121, 1'b1, 1'b1, 32'd1, 1'b1, OS);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        checks++; if (s_dd !== 16'd32760) begin errors++; $display("FAIL sat_pre: got %0d want 32760", $signed(s_dd)); end
        drive(8'd127, 1'b1, 1'b1, 32'd121, 1'b1, OS);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, CLR);
        drive(8'd127, 1'b1, 1'b1, 32'd127, 1'b1, OS);
        drive(8'd127, 1'b1, 1'b1, 32'd127, 1'b1, OS);
        drive(8'd127, 1'b1, 1'b1, 32'd3, 1'b1, OS);
        drive(8'd121, 1'b1, 1'b1, 32'd1, 1'b1, OS);
        drive(8'd127, 1'b1, 1'b1, 32'd1, 1'b1, OS);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        checks++; if (s_dd !== exp16) begin errors++; $display("FAIL sat_16: got %0d want %0d", $signed(s_dd), $signed(exp16)); end
        checks++; if (a_dd !== 32'd32887) begin errors++; $display("FAIL sat_32_nooverflow: got %0d want 32887", $signed(a_dd)); end
    endtask

    task automatic test_protocol_error();
        do_reset();
        drive(8'd5, 1'b1, 1'b1, 32'd1, 1'b1, OS);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        drive(8'd4, 1'b1, 1'b1, 32'd4, 1'b1, OS);
        checks++; if (b_err !== 1'b1 || b_dd !== 32'd4 || b_busy !== 1'b1) begin errors++; $display("FAIL perr_set: got err %0b data %0d busy %0b want 1/4/1", b_err, b_dd, b_busy); end
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, 3'b110);
        checks++; if (b_busy !== 1'b1 || b_vd !== 1'b0) begin errors++; $display("FAIL perr_bubble: got busy %0b valid %0b want 1/0", b_busy, b_vd); end
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b1, NOP);
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL perr_drain_end: got busy %0b want 0", b_busy); end
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        checks++; if (b_dd !== 32'd0 || b_vd !== 1'b1 || b_err !== 1'b1) begin errors++; $display("FAIL perr_acc_kept: got %0d/%0b err %0b want 0/1/1", b_dd, b_vd, b_err); end
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b1, NOP);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b1, NOP);
        checks++; if (b_err !== 1'b1 || b_busy !== 1'b0) begin errors++; $display("FAIL perr_sticky: got err %0b busy %0b want 1/0", b_err, b_busy); end
        do_reset();
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL perr_cleared: got %0b want 0", b_err); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        drive(8'd3, 1'b1, 1'b1, 32'd3, 1'b1, OS);
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        checks++; if (c_dd !== 32'd9 || c_busy !== 1'b1) begin errors++; $display("FAIL mid_own: got %0d busy %0b want 9/1", c_dd, c_busy); end
        drive(8'd1, 1'b1, 1'b1, 32'd11, 1'b1, NOP);
        checks++; if (c_dd !== 32'd11 || c_busy !== 1'b1) begin errors++; $display("FAIL mid_w1: got %0d busy %0b want 11/1", c_dd, c_busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (c_dd !== 32'd0 || c_vd !== 1'b0 || c_cd !== 3'd0) begin errors++; $display("FAIL mid_rst_down: got %0d/%0b/%0d want 0/0/0", c_dd, c_vd, c_cd); end
        checks++; if (c_dr !== 8'd0 || c_vr !== 1'b0 || c_cr !== 1'b0 || c_busy !== 1'b0 || c_err !== 1'b0) begin errors++; $display("FAIL mid_rst_misc: got %0h/%0b/%0b busy %0b err %0b want all 0", c_dr, c_vr, c_cr, c_busy, c_err); end
        #1;
        rst = 1'b0;
        drive(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, DRN);
        checks++; if (c_dd !== 32'd0 || c_vd !== 1'b1 || c_busy !== 1'b1) begin errors++; $display("FAIL mid_redrain: got %0d/%0b busy %0b want 0/1/1", c_dd, c_vd, c_busy); end
        drive(8'd0, 1'b0, 1'b0, 32'd1, 1'b1, NOP);
        drive(8'd0, 1'b0, 1'b0, 32'd2, 1'b1, NOP);
        checks++; if (c_busy !== 1'b1) begin errors++; $display("FAIL mid_count2: got busy %0b want 1", c_busy); end
        drive(8'd0, 1'b0, 1'b0, 32'd3, 1'b1, NOP);
        checks++; if (c_busy !== 1'b0 || c_dd !== 32'd3) begin errors++; $display("FAIL mid_count3: got busy %0b data %0d want 0/3", c_busy, c_dd); end
    endtask

    initial begin
        #3;
        test_reset();
        test_forward();
        test_os_accumulate();
        test_no_mac_and_clear();
        test_drain_chain();
        test_ws();
        test_saturate();
        test_protocol_error();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
